// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline traffic controller.
// Holds the control FSM state encoding and counter helpers.
package pipe_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      ISSUE = 2'd2
   } ctrl_state_t;

   localparam int REG_IDX_W = 5;
   localparam int XLEN      = 64;
   localparam int CNT_W     = 32;

   // Event counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(
      input logic [CNT_W-1:0] v
   );
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/pipe_traffic_ctrl_hazard_detect.sv
// Load-use hazard compare between the load in EX and the consumer in ID.
// Purely combinational; x0 is never a hazard.
module hazard_detect
   import pipe_pkg::*;
(
   input  logic                 ex_valid,
   input  logic                 ex_is_load,
   input  logic [REG_IDX_W-1:0] ex_rd,
   input  logic                 id_valid,
   input  logic [REG_IDX_W-1:0] id_rs1,
   input  logic [REG_IDX_W-1:0] id_rs2,
   input  logic                 id_uses_rs1,
   input  logic                 id_uses_rs2,
   output logic                 load_use
);

   logic rd_nz;
   logic hit1;
   logic hit2;

   assign rd_nz = |ex_rd;
   assign hit1  = id_uses_rs1 && (id_rs1 == ex_rd);
   assign hit2  = id_uses_rs2 && (id_rs2 == ex_rd);

   assign load_use = ex_valid && ex_is_load && rd_nz
                   && id_valid && (hit1 || hit2);

endmodule

// File: rtl/pipe_traffic_ctrl.sv
// Stall/flush/bubble control for the five-stage pipeline registers.
// Priority: redirect > mem_busy > serial drain > load-use > normal.
module pipe_traffic_ctrl
   import pipe_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 id_valid,
   input  logic                 ex_valid,
   input  logic                 mem_valid,
   input  logic                 wb_valid,
   input  logic                 if_ready,
   input  logic                 mem_busy,
   input  logic                 ex_is_load,
   input  logic [REG_IDX_W-1:0] ex_rd,
   input  logic [REG_IDX_W-1:0] id_rs1,
   input  logic [REG_IDX_W-1:0] id_rs2,
   input  logic                 id_uses_rs1,
   input  logic                 id_uses_rs2,
   input  logic                 id_is_serial,
   input  logic                 mem_do_jump,
   input  logic [XLEN-1:0]      mem_jump_target,
   output logic                 id_wr_en,
   output logic                 ex_wr_en,
   output logic                 mem_wr_en,
   output logic                 wb_wr_en,
   output logic                 id_gen_bubble,
   output logic                 ex_gen_bubble,
   output logic                 mem_gen_bubble,
   output logic                 wb_gen_bubble,
   output logic                 pc_wr_en,
   output logic                 redirect_valid,
   output logic [XLEN-1:0]      redirect_pc,
   output logic [CNT_W-1:0]     stall_count,
   output logic [CNT_W-1:0]     flush_count,
   output logic [1:0]           state
);

   ctrl_state_t      state_q, state_d;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;
   logic [CNT_W-1:0] flush_count_q, flush_count_d;

   logic load_use;
   logic redirect;
   logic serial;
   logic any_down;
   logic serial_hold;
   logic stall_evt;

   hazard_detect u_hazard (
      .ex_valid    (ex_valid),
      .ex_is_load  (ex_is_load),
      .ex_rd       (ex_rd),
      .id_valid    (id_valid),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_uses_rs1 (id_uses_rs1),
      .id_uses_rs2 (id_uses_rs2),
      .load_use    (load_use)
   );

   // A jump waiting behind mem_busy stays in MEM, so it redirects later.
   assign redirect = mem_valid && mem_do_jump && !mem_busy;
   assign serial   = id_valid && id_is_serial;
   assign any_down = ex_valid || mem_valid || wb_valid;

   // The serial op is held in ID from the cycle it is first seen.
   assign serial_hold = (state_q == DRAIN)
                     || ((state_q == RUN) && serial);

   assign stall_evt = !redirect
                   && (mem_busy || load_use || (state_q == DRAIN));

   // Per-cycle write enables, bubbles and redirect for each pipe register.
   always_comb begin
      id_wr_en       = 1'b1;
      ex_wr_en       = 1'b1;
      mem_wr_en      = 1'b1;
      wb_wr_en       = 1'b1;
      id_gen_bubble  = !if_ready;
      ex_gen_bubble  = !id_valid;
      mem_gen_bubble = !ex_valid;
      wb_gen_bubble  = !mem_valid;
      pc_wr_en       = if_ready;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      if (reset) begin
         id_gen_bubble  = 1'b1;
         ex_gen_bubble  = 1'b1;
         mem_gen_bubble = 1'b1;
         wb_gen_bubble  = 1'b1;
         pc_wr_en       = 1'b0;
      end else if (redirect) begin
         id_gen_bubble  = 1'b1;
         ex_gen_bubble  = 1'b1;
         mem_gen_bubble = 1'b1;
         wb_gen_bubble  = 1'b0;
         pc_wr_en       = 1'b1;
         redirect_valid = 1'b1;
         redirect_pc    = mem_jump_target;
      end else if (mem_busy) begin
         id_wr_en      = 1'b0;
         ex_wr_en      = 1'b0;
         mem_wr_en     = 1'b0;
         wb_gen_bubble = 1'b1;
         pc_wr_en      = 1'b0;
      end else if (serial_hold) begin
         id_wr_en      = 1'b0;
         ex_gen_bubble = 1'b1;
         pc_wr_en      = 1'b0;
      end else if (state_q == ISSUE) begin
         ex_gen_bubble = 1'b0;
         id_gen_bubble = 1'b1;
         pc_wr_en      = 1'b0;
      end else if (load_use) begin
         id_wr_en      = 1'b0;
         ex_gen_bubble = 1'b1;
         pc_wr_en      = 1'b0;
      end
   end

   // Next FSM state and saturating event counters.
   always_comb begin
      state_d       = state_q;
      stall_count_d = stall_count_q;
      flush_count_d = flush_count_q;
      if (reset) begin
         state_d       = RUN;
         stall_count_d = '0;
         flush_count_d = '0;
      end else begin
         unique case (state_q)
            RUN: begin
               if (serial && !mem_busy)
                  state_d = any_down ? DRAIN : ISSUE;
            end
            DRAIN: begin
               if (!any_down)
                  state_d = ISSUE;
            end
            ISSUE:   state_d = RUN;
            default: state_d = RUN;
         endcase
         if (redirect) begin
            state_d       = RUN;
            flush_count_d = sat_inc(flush_count_q);
         end
         if (stall_evt)
            stall_count_d = sat_inc(stall_count_q);
      end
   end

   // State and counter registers.
   always_ff @(posedge clk) begin
      state_q       <= state_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
   end

   assign stall_count = stall_count_q;
   assign flush_count = flush_count_q;
   assign state       = state_q;

endmodule
